// File: rtl/alu_addsub_nibble.sv
// Multi-cycle add/subtract unit: one 4-bit CLA slice swept LSB to MSB,
// ripple carry registered between nibbles, flags captured with the last nibble.

module alu_cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    assign p = a ^ b;
    assign g = a & b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign sum  = p ^ c[3:0];
    assign cout = c[4];

endmodule

module alu_addsub_nibble #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_cout,
    output logic             o_ovf,
    output logic             o_zero,
    output logic             o_lt,
    output logic             o_ltu
);

    localparam int N  = WIDTH / 4;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] work_q;
    logic [WIDTH-1:0] work_d;
    logic             carry_q;
    logic             sub_q;
    logic [KW-1:0]    k_q;

    logic [WIDTH-1:0] res_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;
    logic             lt_q;
    logic             ltu_q;

    logic [3:0] a_nib;
    logic [3:0] b_nib;
    logic [3:0] sum;
    logic       c_out;
    logic       accept;
    logic       last;
    logic       ovf_d;
    logic       zero_d;
    logic       lt_d;
    logic       ltu_d;

    assign accept = i_valid & o_ready;
    assign last   = (state_q == RUN) && (k_q == K_LAST);

    // FSM: state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (i_valid) state_d = RUN;
            RUN:     if (k_q == K_LAST) state_d = DONE;
            DONE:    if (i_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        o_ready = (state_q == IDLE);
        o_valid = (state_q == DONE);
    end

    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int i = 0; i < N; i++) begin
            if (k_q == KW'(i)) begin
                a_nib = a_q[4*i +: 4];
                b_nib = b_q[4*i +: 4];
            end
        end
    end

    alu_cla4 u_slice (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry_q),
        .sum  (sum),
        .cout (c_out)
    );

    always_comb begin
        work_d = work_q;
        for (int i = 0; i < N; i++) begin
            if (k_q == KW'(i)) begin
                work_d[4*i +: 4] = sum;
            end
        end
    end

    // Only meaningful on the last nibble, where sum[3] is the result MSB
    always_comb begin
        ovf_d  = (a_q[WIDTH-1] == b_q[WIDTH-1])
               & (sum[3] != a_q[WIDTH-1]);
        zero_d = (work_d == '0);
        lt_d   = sub_q & (sum[3] ^ ovf_d);
        ltu_d  = sub_q & ~c_out;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            k_q     <= '0;
        end else if (accept) begin
            a_q     <= i_a;
            b_q     <= i_b ^ {WIDTH{i_sub}};
            carry_q <= i_sub;
            sub_q   <= i_sub;
            k_q     <= '0;
        end else if (state_q == RUN) begin
            work_q  <= work_d;
            carry_q <= c_out;
            k_q     <= last ? '0 : k_q + KW'(1);
        end
    end

    // Visible results change only when the final nibble lands
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            res_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            lt_q   <= 1'b0;
            ltu_q  <= 1'b0;
        end else if (last) begin
            res_q  <= work_d;
            cout_q <= c_out;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
            lt_q   <= lt_d;
            ltu_q  <= ltu_d;
        end
    end

    assign o_result = res_q;
    assign o_cout   = cout_q;
    assign o_ovf    = ovf_q;
    assign o_zero   = zero_q;
    assign o_lt     = lt_q;
    assign o_ltu    = ltu_q;

endmodule

// File: tb/tb_alu_addsub_nibble.sv
// Directed bench for alu_addsub_nibble with a queue-based scoreboard.

module tb_alu_addsub_nibble;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic        i_sub;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_result;
    logic        o_cout;
    logic        o_ovf;
    logic        o_zero;
    logic        o_lt;
    logic        o_ltu;

    alu_addsub_nibble #(.WIDTH(32)) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_a      (i_a),
        .i_b      (i_b),
        .i_sub    (i_sub),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result),
        .o_cout   (o_cout),
        .o_ovf    (o_ovf),
        .o_zero   (o_zero),
        .o_lt     (o_lt),
        .o_ltu    (o_ltu)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [31:0] r;
        logic        c;
        logic        v;
        logic        z;
        logic        lt;
        logic        ltu;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic s);
        exp_t        e;
        logic [32:0] full;
        if (s) full = {1'b0, a} - {1'b0, b};
        else   full = {1'b0, a} + {1'b0, b};
        e.r = full[31:0];
        // carry out: for subtract it is "no borrow"
        e.c = s ? (a >= b) : full[32];
        if (s) e.v = (a[31] != b[31]) && (e.r[31] != a[31]);
        else   e.v = (a[31] == b[31]) && (e.r[31] != a[31]);
        e.z   = (e.r == 32'd0);
        e.lt  = s && ($signed(a) < $signed(b));
        e.ltu = s && (a < b);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic s);
        check("ready_at_issue", {31'd0, o_ready}, 32'd1);
        i_a     = a;
        i_b     = b;
        i_sub   = s;
        i_valid = 1'b1;
        q.push_back(model(a, b, s));
        tick();
        i_valid = 1'b0;
    endtask

    // lat counts cycles from the request cycle to the first o_valid cycle
    task automatic collect(output int lat);
        exp_t e;
        lat = 1;
        while (!o_valid && lat < 40) begin
            tick();
            lat++;
        end
        check("valid_seen", {31'd0, o_valid}, 32'd1);
        check("sb_nonempty", {31'd0, q.size() != 0}, 32'd1);
        if (o_valid && q.size() != 0) begin
            e = q.pop_front();
            check("result", o_result, e.r);
            check("cout", {31'd0, o_cout}, {31'd0, e.c});
            check("ovf", {31'd0, o_ovf}, {31'd0, e.v});
            check("zero", {31'd0, o_zero}, {31'd0, e.z});
            check("lt", {31'd0, o_lt}, {31'd0, e.lt});
            check("ltu", {31'd0, o_ltu}, {31'd0, e.ltu});
        end
    endtask

    task automatic retire();
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        check("valid_drop", {31'd0, o_valid}, 32'd0);
        check("ready_back", {31'd0, o_ready}, 32'd1);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic s);
        int lat;
        issue(a, b, s);
        collect(lat);
        check("latency", lat, 32'd9);
        retire();
    endtask

    initial begin
        int          lat;
        logic [31:0] snap_r;
        logic [4:0]  snap_f;

        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_a     = '0;
        i_b     = '0;
        i_sub   = 1'b0;
        #12;
        check("rst_ready", {31'd0, o_ready}, 32'd1);
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_result", o_result, 32'd0);
        check("rst_flags", {27'd0, o_cout, o_ovf, o_zero, o_lt, o_ltu}, 32'd0);
        tick();
        i_rst_n = 1'b1;
        tick();

        // add wrap to zero, with i_ready held high throughout
        i_ready = 1'b1;
        issue(32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
        collect(lat);
        check("latency_first", lat, 32'd9);
        check("zero_literal", {31'd0, o_zero}, 32'd1);
        tick();
        check("valid_drop_hold", {31'd0, o_valid}, 32'd0);
        i_ready = 1'b0;

        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        run_op(32'h0000_0005, 32'h0000_0007, 1'b1);
        run_op(32'h8000_0000, 32'h0000_0001, 1'b1);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(32'h0000_0000, 32'h0000_0001, 1'b1);

        for (int i = 0; i < 6; i++) begin
            run_op($urandom, $urandom, 1'(i % 2));
        end

        // backpressure plus an ignored request during RUN/DONE
        issue(32'h1234_5678, 32'h1234_5678, 1'b1);
        tick();
        i_valid = 1'b1;
        i_a     = 32'hDEAD_BEEF;
        i_b     = 32'h0000_0001;
        i_sub   = 1'b0;
        collect(lat);
        check("bp_zero", {31'd0, o_zero}, 32'd1);
        check("bp_cout", {31'd0, o_cout}, 32'd1);
        snap_r = o_result;
        snap_f = {o_cout, o_ovf, o_zero, o_lt, o_ltu};
        for (int i = 0; i < 5; i++) begin
            i_a = i_a + 32'h0101_0101;
            tick();
            check("bp_valid", {31'd0, o_valid}, 32'd1);
            check("bp_ready", {31'd0, o_ready}, 32'd0);
            check("bp_result", o_result, snap_r);
            check("bp_flags", {27'd0, o_cout, o_ovf, o_zero, o_lt, o_ltu},
                  {27'd0, snap_f});
        end
        i_valid = 1'b0;
        retire();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_no_extra", {31'd0, o_valid}, 32'd0);
        end
        check("bp_sb_empty", q.size(), 32'd0);

        // reset with k == 3 of an add
        issue(32'h1111_1111, 32'h2222_2222, 1'b0);
        tick();
        tick();
        tick();
        check("mid_not_valid", {31'd0, o_valid}, 32'd0);
        #1;
        i_rst_n = 1'b0;
        #1;
        check("mr_valid", {31'd0, o_valid}, 32'd0);
        check("mr_ready", {31'd0, o_ready}, 32'd1);
        check("mr_result", o_result, 32'd0);
        check("mr_flags", {27'd0, o_cout, o_ovf, o_zero, o_lt, o_ltu}, 32'd0);
        q.delete();
        tick();
        tick();
        i_rst_n = 1'b1;
        tick();
        for (int i = 0; i < 12; i++) begin
            tick();
            check("mr_no_partial", {31'd0, o_valid}, 32'd0);
        end
        run_op(32'h0F0F_0F0F, 32'h0101_0101, 1'b0);
        check("mr_after_result", o_result, 32'h1010_1010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
